serial_word_rx: RTL and testbench
=================================

Name: serial_word_rx

Overview:
- Downstream consumer of the 5-bit universal shift register's serial output (SO).
- Deframes a start/data/stop bit stream, sampling only on qualified bit-enable cycles.
- Reassembles each data word into parallel form.
- Presents the word through a single-entry valid/ready output buffer and flags framing errors and overruns.

Parameters:
- WIDTH, 5, data bits per frame (legal range 2..16)
- MSB_FIRST, 0, 0 = first data bit on the wire is the LSB (shift-right source); 1 = first bit is the MSB (shift-left source)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  qualifies sin; sin is sampled only on edges where bit_en=1
- sin  input  1  serial data in; idle level is 1
- data_out  output  WIDTH  received word, stable while data_valid=1
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts the word on any edge where data_valid & data_ready
- busy  output  1  high in DATA or STOP state
- frame_err  output  1  one-cycle pulse: bad stop bit
- overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full

Behaviour:
- Reset:
  - Sampled on the rising edge; rst=1 dominates all other inputs.
  - Forces state=IDLE, bit counter=0, shift reg=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial word.
  - Reset while data_valid=1 drops the buffered word.
- Edges with bit_en=0 change no FSM, counter or shift-reg state. The handshake still operates on those edges.
- FSM states: IDLE, DATA, STOP.
  - IDLE: on bit_en & sin=0 (start bit), go to DATA and clear the counter. sin=1 stays in IDLE.
  - DATA: on each bit_en, shift in sin and increment the counter.
    - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
    - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
    - After the WIDTH-th data bit, go to STOP. There is no early exit.
  - STOP: on bit_en, always return to IDLE, then:
    - sin=1 and buffer free: data_out <= shreg and data_valid <= 1 on that same edge.
    - Buffer free means data_valid=0, or data_valid & data_ready on that edge (simultaneous drain and load are allowed, with no bubble).
    - sin=1 and buffer full (data_valid=1, data_ready=0): overrun=1 for the next cycle only. The new word is dropped; data_out and data_valid are unchanged.
    - sin=0: frame_err=1 for the next cycle only. The word is discarded and the buffer is unchanged.
    - A 0 on the stop-bit slot is NOT reinterpreted as a new start bit. The FSM goes to IDLE and waits for a fresh 0.
- Latency: data_valid rises in the cycle after the edge that samples a good stop bit.
- Handshake:
  - data_valid clears on the edge where data_valid & data_ready, unless a new word loads on that same edge.
  - data_ready while data_valid=0 is ignored.
  - data_out changes only on a load.
- busy=1 exactly while state is DATA or STOP, registered with the state.
- frame_err and overrun never assert together, and each lasts exactly one clk cycle.
- Counter width is clog2(WIDTH+1), with no wrap inside a frame.
- Back-to-back frames: a start bit may arrive on the first bit_en after STOP. There is no required idle gap.

Test Plan:
- Reset, WIDTH=5, MSB_FIRST=0, bit_en=1 every cycle, data_ready=0. Send 0 | 1,0,1,1,0 | 1 -> data_out=5'b01101, data_valid=1 one cycle after the stop edge, busy low afterwards.
- MSB_FIRST=1, bit_en high every 3rd cycle. Send 0 | 1,0,0,1,1 | 1 -> data_out=5'b10011. No state change on gap cycles.
- Stop slot sin=0 after data 5'b11111 -> frame_err pulses for 1 cycle, data_valid stays 0. Next valid frame 5'b00001 is received correctly.
- Hold data_ready=0 and send two good frames (5'b01101, then 5'b10010) -> second stop causes a 1-cycle overrun pulse, data_out stays 5'b01101. Then data_ready=1 -> data_valid drops next cycle.
- data_ready=1 on the exact edge the second frame's stop bit is sampled, with word A buffered -> A consumed, B=5'b10010 loaded, data_valid stays 1, no overrun.
- Assert rst for 1 cycle after the 3rd data bit -> all outputs 0, state IDLE. A following full frame 5'b00110 is received intact.

Source files
------------

// File: rtl/serial_word_rx_if.sv
// Serial receive bus: qualified serial input plus valid/ready word output and status pulses.
interface serial_word_rx_if #(
  parameter int unsigned WIDTH = 5
);
  logic             bit_en;
  logic             sin;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  // master = serial source and word consumer; slave = the receiver
  modport master (
    output bit_en,
    output sin,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  bit_en,
    input  sin,
    input  data_ready,
    output data_out,
    output data_valid,
    output busy,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/serial_word_rx.sv
// Start/data/stop deframer for a shift-register serial stream with a single-entry
// valid/ready output buffer, framing-error and overrun pulses.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 5,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           rst,
  serial_word_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             drain;
  logic             buf_free;

  // Shift direction follows the source register: LSB-first enters at the top.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_d = {shreg_q[WIDTH-2:0], bus.sin};
    end else begin : g_lsb_first
      assign shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign cnt_d    = cnt_q + CW'(1);
  assign drain    = valid_q & bus.data_ready;
  assign buf_free = ~valid_q | bus.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (drain) begin
        valid_q <= 1'b0;
      end
      if (bus.bit_en) begin
        case (state_q)
          IDLE: begin
            if (!bus.sin) begin
              state_q <= DATA;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            if (cnt_q == LAST_IDX) begin
              state_q <= STOP;
            end
          end
          STOP: begin
            // A low stop bit is an error only; it never doubles as a start bit.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bus.sin) begin
              if (buf_free) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Drives one serial stream into an LSB-first and an MSB-first receiver and checks both
// against a queue-based frame model every cycle, plus directed literal expectations.
module tb_serial_word_rx;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b0;
  logic sin = 1'b1;
  logic data_ready = 1'b0;

  serial_word_rx_if #(.WIDTH(W)) bus0 ();
  serial_word_rx_if #(.WIDTH(W)) bus1 ();

  assign bus0.bit_en     = bit_en;
  assign bus0.sin        = sin;
  assign bus0.data_ready = data_ready;
  assign bus1.bit_en     = bit_en;
  assign bus1.sin        = sin;
  assign bus1.data_ready = data_ready;

  serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a frame is a start 0, then W sampled bits, then a stop slot.
  bit           m_live = 1'b0;
  bit           m_in_frame = 1'b0;
  int           m_bits[$];
  logic [W-1:0] m_dout0 = '0;
  logic [W-1:0] m_dout1 = '0;
  bit           m_dv = 1'b0;
  bit           m_fe = 1'b0;
  bit           m_ov = 1'b0;

  always @(negedge clk) begin : p_model
    bit drain;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    if (m_live) begin
      check("dut0 data_out",   bus0.data_out,   m_dout0);
      check("dut1 data_out",   bus1.data_out,   m_dout1);
      check("dut0 data_valid", bus0.data_valid, m_dv);
      check("dut1 data_valid", bus1.data_valid, m_dv);
      check("dut0 busy",       bus0.busy,       m_in_frame);
      check("dut1 busy",       bus1.busy,       m_in_frame);
      check("dut0 frame_err",  bus0.frame_err,  m_fe);
      check("dut1 frame_err",  bus1.frame_err,  m_fe);
      check("dut0 overrun",    bus0.overrun,    m_ov);
      check("dut1 overrun",    bus1.overrun,    m_ov);
    end
    // advance the model by the inputs the next rising edge will sample
    if (rst) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_dv = 1'b0;
      m_dout0 = '0;
      m_dout1 = '0;
      m_fe = 1'b0;
      m_ov = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_fe = 1'b0;
      m_ov = 1'b0;
      drain = m_dv && data_ready;
      if (bit_en) begin
        if (!m_in_frame) begin
          if (!sin) begin
            m_in_frame = 1'b1;
            m_bits.delete();
          end
        end else if (m_bits.size() < W) begin
          m_bits.push_back(int'(sin));
        end else begin
          m_in_frame = 1'b0;
          if (sin) begin
            if (!m_dv || data_ready) begin
              w0 = '0;
              w1 = '0;
              for (int i = 0; i < W; i++) begin
                w0 = w0 | (W'(m_bits[i]) << i);
                w1 = w1 | (W'(m_bits[i]) << (W - 1 - i));
              end
              m_dout0 = w0;
              m_dout1 = w1;
              m_dv = 1'b1;
              drain = 1'b0;
              $display("rx word: lsb-first=%b msb-first=%b (t=%0t)", w0, w1, $time);
            end else begin
              m_ov = 1'b1;
              $display("rx overrun: word dropped (t=%0t)", $time);
            end
          end else begin
            m_fe = 1'b1;
            $display("rx framing error (t=%0t)", $time);
          end
        end
      end
      if (drain) m_dv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_en = 1'b0;
      sin = 1'($urandom);
      tick();
    end
    bit_en = 1'b1;
    sin = b;
    tick();
    bit_en = 1'b0;
    sin = 1'b1;
  endtask

  // wire_bits[W-1] goes on the wire first
  task automatic send_frame(input logic [W-1:0] wire_bits, input logic stop, input int gap,
                            input bit ready_at_stop);
    tx_bit(1'b0, gap);
    for (int i = W - 1; i >= 0; i--) tx_bit(wire_bits[i], gap);
    if (ready_at_stop) data_ready = 1'b1;
    tx_bit(stop, gap);
    data_ready = 1'b0;
  endtask

  task automatic drain_buf();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset data_valid", bus0.data_valid, 1'b0);
    check("reset data_out",   bus0.data_out,   5'b00000);
    check("reset busy",       bus1.busy,       1'b0);

    // basic LSB-first / MSB-first reception
    send_frame(5'b10110, 1'b1, 0, 1'b0);
    $display("txn t1: frame 1,0,1,1,0 sent");
    check("t1 lsb data_out", bus0.data_out,   5'b01101);
    check("t1 msb data_out", bus1.data_out,   5'b10110);
    check("t1 data_valid",   bus0.data_valid, 1'b1);
    check("t1 busy",         bus0.busy,       1'b0);

    // bit_en every third cycle
    drain_buf();
    send_frame(5'b10011, 1'b1, 2, 1'b0);
    $display("txn t2: frame 1,0,0,1,1 sent with gaps");
    check("t2 msb data_out", bus1.data_out, 5'b10011);
    check("t2 lsb data_out", bus0.data_out, 5'b11001);

    // bad stop bit, then a good frame
    drain_buf();
    send_frame(5'b11111, 1'b0, 0, 1'b0);
    $display("txn t3: frame 11111 with bad stop sent");
    check("t3 frame_err",    bus0.frame_err,  1'b1);
    check("t3 data_valid",   bus0.data_valid, 1'b0);
    check("t3 no overrun",   bus0.overrun,    1'b0);
    tick();
    check("t3 frame_err end", bus0.frame_err, 1'b0);
    send_frame(5'b10000, 1'b1, 0, 1'b0);
    check("t3 next data_out", bus0.data_out,   5'b00001);
    check("t3 next valid",    bus0.data_valid, 1'b1);

    // overrun with buffer held full
    drain_buf();
    send_frame(5'b10110, 1'b1, 0, 1'b0);
    send_frame(5'b01001, 1'b1, 0, 1'b0);
    $display("txn t4: two frames into a full buffer");
    check("t4 overrun",      bus0.overrun,    1'b1);
    check("t4 kept data",    bus0.data_out,   5'b01101);
    check("t4 still valid",  bus0.data_valid, 1'b1);
    tick();
    check("t4 overrun end",  bus0.overrun,    1'b0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t4 drained",      bus0.data_valid, 1'b0);

    // drain and load on the same edge
    send_frame(5'b10110, 1'b1, 0, 1'b0);
    send_frame(5'b01001, 1'b1, 0, 1'b1);
    $display("txn t5: simultaneous drain and load");
    check("t5 valid",        bus0.data_valid, 1'b1);
    check("t5 data_out",     bus0.data_out,   5'b10010);
    check("t5 no overrun",   bus0.overrun,    1'b0);

    // reset mid-frame with a word still buffered
    tx_bit(1'b0, 0);
    tx_bit(1'b0, 0);
    tx_bit(1'b1, 0);
    tx_bit(1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn t6: reset mid-frame");
    check("t6 valid cleared", bus0.data_valid, 1'b0);
    check("t6 data cleared",  bus0.data_out,   5'b00000);
    check("t6 busy cleared",  bus0.busy,       1'b0);
    send_frame(5'b01100, 1'b1, 0, 1'b0);
    check("t6 data_out",      bus0.data_out,   5'b00110);
    check("t6 valid",         bus0.data_valid, 1'b1);

    // random stream: bit_en, sin, data_ready and rare resets
    repeat (4000) begin
      bit_en = ($urandom_range(0, 2) != 0);
      sin = 1'($urandom);
      data_ready = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    bit_en = 1'b0;
    data_ready = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
